// File: rtl/sdram_port_queue_if.sv
// sdram_port_queue_if: host request/response and SDRAM controller port signals of the port queue.
// Latency: none (wires only).
// Backpressure: carried by req_ready (host side) and port_available (controller side).
interface sdram_port_queue_if #(
   parameter int ADDR_WIDTH = 21,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = 4,
   parameter int DEPTH      = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   // host side
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_data;
   logic [BE_WIDTH-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic [CW-1:0]         count;
   logic                  timeout_err;

   // controller side
   logic [ADDR_WIDTH-1:0] port_addr;
   logic [DATA_WIDTH-1:0] port_data;
   logic [BE_WIDTH-1:0]   port_byte_en;
   logic                  port_wr;
   logic                  port_rd;
   logic                  port_available;
   logic                  port_ready;
   logic [DATA_WIDTH-1:0] port_q;

   // the queue itself
   modport slave (
      input  req_valid, req_we, req_addr, req_data, req_be,
      input  port_available, port_ready, port_q,
      output req_ready, rsp_valid, rsp_data, count, timeout_err,
      output port_addr, port_data, port_byte_en, port_wr, port_rd
   );

   // host plus controller environment around the queue
   modport master (
      output req_valid, req_we, req_addr, req_data, req_be,
      output port_available, port_ready, port_q,
      input  req_ready, rsp_valid, rsp_data, count, timeout_err,
      input  port_addr, port_data, port_byte_en, port_wr, port_rd
   );
endinterface

// File: rtl/sdram_port_queue.sv
// sdram_port_queue: FIFO of host read/write requests issued one at a time to an SDRAM controller port.
// Latency: accept at edge C -> port strobe in the cycle after edge C+1; read data pulsed the cycle after port_ready.
// Backpressure: req_ready = !full; port_available stalls issue. Optional WAIT watchdog: SDRAM_PORT_QUEUE_TIMEOUT_EN.
module sdram_port_queue #(
   parameter int ADDR_WIDTH     = 21,
   parameter int DATA_WIDTH     = 32,
   parameter int BE_WIDTH       = 4,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   sdram_port_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_chk
      $error("sdram_port_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYCLES >= 1");
   end

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
      logic [BE_WIDTH-1:0]   be;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   entry_t                mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]         count_q;
   state_t                state_q, state_d;
   entry_t                cur_q, cur_d;
   logic                  port_wr_q, port_wr_d;
   logic                  port_rd_q, port_rd_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  full, empty, push, pop;
   logic                  timeout_hit;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.req_valid && !full;

   assign bus.req_ready    = !full;
   assign bus.count        = count_q;
   assign bus.port_addr    = cur_q.addr;
   assign bus.port_data    = cur_q.data;
   assign bus.port_byte_en = cur_q.be;
   assign bus.port_wr      = port_wr_q;
   assign bus.port_rd      = port_rd_q;
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;

   // Queue storage: contents need no reset, emptiness is carried by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{we: bus.req_we, addr: bus.req_addr, data: bus.req_data, be: bus.req_be};
      end
   end

   // Pointers wrap naturally modulo DEPTH; push+pop in one cycle leaves count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef SDRAM_PORT_QUEUE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] wait_cnt_q;
   logic          timeout_err_q;

   assign timeout_hit     = (state_q == WAIT) && !bus.port_ready && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
   assign bus.timeout_err = timeout_err_q;

   // Count cycles spent in WAIT; restarts on every new operation.
   always_ff @(posedge clk) begin
      if (reset || state_q != WAIT) wait_cnt_q <= '0;
      else                          wait_cnt_q <= wait_cnt_q + TW'(1);
   end

   // Watchdog flag stays set until reset.
   always_ff @(posedge clk) begin
      if (reset)            timeout_err_q <= 1'b0;
      else if (timeout_hit) timeout_err_q <= 1'b1;
   end
`else
   assign timeout_hit     = 1'b0;
   assign bus.timeout_err = 1'b0;
`endif

   // FSM and registered port/response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         port_wr_q   <= 1'b0;
         port_rd_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         port_wr_q   <= port_wr_d;
         port_rd_q   <= port_rd_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   // Next state: the head is popped and latched into the port registers on entry to ISSUE,
   // so strobes are high exactly while in ISSUE and the port values hold through WAIT.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      port_wr_d   = 1'b0;
      port_rd_d   = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty && bus.port_available) begin
               pop       = 1'b1;
               cur_d     = mem_q[rd_ptr_q];
               port_wr_d = mem_q[rd_ptr_q].we;
               port_rd_d = !mem_q[rd_ptr_q].we;
               state_d   = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (bus.port_ready) begin
               state_d = IDLE;
               if (!cur_q.we) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = bus.port_q;
               end
            end else if (timeout_hit) begin
               state_d = IDLE;
               if (!cur_q.we) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_sdram_port_queue.sv
// tb_sdram_port_queue: directed bench with a transaction-level model checked every cycle.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_sdram_port_queue;
   localparam int AW = 21, DW = 32, BW = 4, DEPTH = 4, TO = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sdram_port_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .DEPTH(DEPTH)) bus ();

   sdram_port_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .DEPTH(DEPTH),
                      .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model: queue of requests plus one outstanding operation
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } req_t;

   req_t          mq[$];
   req_t          out_req;
   bit            out_busy = 0, in_issue = 0, model_on = 0, acc;
   int            age = 0;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_data, e_rsp_dat;
   logic [BW-1:0] e_be;
   bit            e_rsp_vld = 0, e_terr = 0;

   always @(posedge clk) begin
      if (reset) begin
         mq.delete();
         out_req  = '0;
         out_busy = 0; in_issue = 0; age = 0;
         e_addr = '0; e_data = '0; e_be = '0;
         e_rsp_vld = 0; e_rsp_dat = '0; e_terr = 0;
         model_on = 1;
      end else if (model_on) begin
         acc       = bus.req_valid && (mq.size() < DEPTH);
         e_rsp_vld = 0;
         if (out_busy) begin
            if (in_issue) begin
               in_issue = 0;
               age      = 0;
            end else if (bus.port_ready) begin
               out_busy = 0;
               if (!out_req.we) begin e_rsp_vld = 1; e_rsp_dat = bus.port_q; end
            end
`ifdef SDRAM_PORT_QUEUE_TIMEOUT_EN
            else begin
               age++;
               if (age == TO) begin
                  out_busy = 0;
                  e_terr   = 1;
                  if (!out_req.we) begin e_rsp_vld = 1; e_rsp_dat = '0; end
               end
            end
`endif
         end else if (mq.size() > 0 && bus.port_available) begin
            out_req  = mq.pop_front();
            out_busy = 1; in_issue = 1;
            e_addr = out_req.addr; e_data = out_req.data; e_be = out_req.be;
         end
         if (acc) mq.push_back('{we: bus.req_we, addr: bus.req_addr, data: bus.req_data, be: bus.req_be});
      end
   end

   // ---------------- per-cycle compare against the model
   always @(negedge clk) begin
      if (model_on) begin
         chk("count",       64'(bus.count),        64'(mq.size()));
         chk("req_ready",   64'(bus.req_ready),    64'(mq.size() < DEPTH));
         chk("port_wr",     64'(bus.port_wr),      64'(in_issue && out_req.we));
         chk("port_rd",     64'(bus.port_rd),      64'(in_issue && !out_req.we));
         chk("wr_rd_excl",  64'(bus.port_wr && bus.port_rd), 64'(0));
         chk("port_addr",   64'(bus.port_addr),    64'(e_addr));
         chk("port_data",   64'(bus.port_data),    64'(e_data));
         chk("port_be",     64'(bus.port_byte_en), 64'(e_be));
         chk("rsp_valid",   64'(bus.rsp_valid),    64'(e_rsp_vld));
         chk("rsp_data",    64'(bus.rsp_data),     64'(e_rsp_dat));
         chk("timeout_err", 64'(bus.timeout_err),  64'(e_terr));
      end
   end

   // ---------------- controller emulation: small memory, answers after rsp_delay WAIT cycles
   bit            auto_rsp = 1, stray_rdy = 0, pend = 0;
   int            rsp_delay = 1, pcnt = 0;
   logic [DW-1:0] stray_q = '0, pval = '0;
   logic [DW-1:0] cmem [int];
   logic [AW-1:0] issue_log[$];

   always @(negedge clk) begin
      if (reset) begin
         pend = 0;
         bus.port_ready = 1'b0;
         bus.port_q     = '0;
      end else begin
         bus.port_ready = stray_rdy;
         bus.port_q     = stray_q;
         if (bus.port_wr || bus.port_rd) begin
            issue_log.push_back(bus.port_addr);
            if (!cmem.exists(int'(bus.port_addr))) cmem[int'(bus.port_addr)] = '0;
            if (bus.port_wr) begin
               for (int b = 0; b < BW; b++)
                  if (bus.port_byte_en[b]) cmem[int'(bus.port_addr)][8*b +: 8] = bus.port_data[8*b +: 8];
            end
            pval = cmem[int'(bus.port_addr)];
            pend = 1;
            pcnt = rsp_delay;
         end else if (pend && auto_rsp) begin
            if (pcnt == 0) begin
               bus.port_ready = 1'b1;
               bus.port_q     = pval;
               pend           = 0;
            end else begin
               pcnt--;
            end
         end
      end
   end

   // ---------------- stimulus helpers (called at a falling edge, return at a falling edge)
   task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
      int n = 0;
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_data = d; bus.req_be = be;
      while (!bus.req_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("push_accept_timeout", 64'(0), 64'(1));
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   function automatic logic sel(input int w);
      case (w)
         0:       return bus.port_wr;
         1:       return bus.port_rd;
         default: return bus.rsp_valid;
      endcase
   endfunction

   task automatic wait_sig(input string name, input int w, input int maxc);
      int n = 0;
      while (!sel(w) && n < maxc) begin @(negedge clk); n++; end
      chk(name, 64'(sel(w)), 64'(1));
   endtask

   // ---------------- watchdog on the whole run
   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------- directed sequence
   initial begin
      int n;
      reset = 1'b1;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_be = '0;
      bus.port_available = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_count",     64'(bus.count),     64'(0));
      chk("rst_req_ready", 64'(bus.req_ready), 64'(1));
      chk("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
      chk("rst_port_addr", 64'(bus.port_addr), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      // single write: strobe in the cycle after the edge following acceptance
      push(1'b1, 21'h002020, 32'h0000_1234, 4'hF);
      chk("wr_c1_port_wr", 64'(bus.port_wr), 64'(0));
      chk("wr_c1_count",   64'(bus.count),   64'(1));
      @(negedge clk);
      chk("wr_c2_port_wr",   64'(bus.port_wr),   64'(1));
      chk("wr_c2_port_addr", 64'(bus.port_addr), 64'h2020);
      chk("wr_c2_port_data", 64'(bus.port_data), 64'h1234);
      repeat (8) @(negedge clk);

      // read back
      push(1'b0, 21'h002020, 32'h0, 4'hF);
      wait_sig("rd_rsp_seen", 2, 20);
      chk("rd_rsp_data", 64'(bus.rsp_data), 64'h1234);
      @(negedge clk);
      chk("rd_rsp_pulse_end", 64'(bus.rsp_valid), 64'(0));

      // fill with port unavailable, 5th held off, then drain in order
      bus.port_available = 1'b0;
      rsp_delay = 2;
      issue_log.delete();
      for (int i = 1; i <= 4; i++) push(logic'(i % 2), AW'(32'h100 + i), 32'hC000_0000 + i, 4'(i));
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 21'h105; bus.req_data = 32'h5555_0005; bus.req_be = 4'h3;
      repeat (3) @(negedge clk);
      chk("full_req_ready", 64'(bus.req_ready), 64'(0));
      chk("full_count",     64'(bus.count),     64'(4));
      bus.port_available = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      chk("fifth_ready", 64'(bus.req_ready), 64'(1));
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (60) @(negedge clk);
      chk("order5_len", 64'(issue_log.size()), 64'(5));
      for (int i = 0; i < 5 && i < issue_log.size(); i++)
         chk("order5_addr", 64'(issue_log[i]), 64'(32'h101 + i));

      // simultaneous push and issue at count 2
      bus.port_available = 1'b0;
      push(1'b1, 21'h201, 32'h2, 4'hF);
      push(1'b0, 21'h202, 32'h0, 4'hF);
      chk("pp_count_before", 64'(bus.count), 64'(2));
      bus.port_available = 1'b1;
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 21'h203; bus.req_data = 32'h3; bus.req_be = 4'hF;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("pp_count_after", 64'(bus.count), 64'(2));
      repeat (40) @(negedge clk);

      // nine requests to wrap the pointers
      issue_log.delete();
      rsp_delay = 0;
      for (int i = 0; i < 9; i++) push(logic'(i % 3 != 0), AW'(32'h300 + i), 32'hA000_0000 + i, 4'(i + 1));
      repeat (80) @(negedge clk);
      chk("wrap_len", 64'(issue_log.size()), 64'(9));
      for (int i = 0; i < 9 && i < issue_log.size(); i++)
         chk("wrap_addr", 64'(issue_log[i]), 64'(32'h300 + i));

      // stray port_ready while idle is ignored
      stray_q = 32'hDEAD_BEEF; stray_rdy = 1;
      repeat (3) @(negedge clk);
      stray_rdy = 0;
      repeat (2) @(negedge clk);
      chk("stray_no_rsp", 64'(bus.rsp_valid), 64'(0));

      // reset while a read waits, with a write still queued
      auto_rsp = 0;
      push(1'b0, 21'h400, 32'h0, 4'hF);
      push(1'b1, 21'h401, 32'h1, 4'hF);
      wait_sig("rst_rd_issued", 1, 10);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_count",   64'(bus.count),   64'(0));
      chk("midrst_port_rd", 64'(bus.port_rd), 64'(0));
      chk("midrst_port_wr", 64'(bus.port_wr), 64'(0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'(0));
      end
      auto_rsp = 1;
      issue_log.delete();
      push(1'b1, 21'h410, 32'h0000_0410, 4'hF);
      @(negedge clk);
      chk("postrst_port_wr",   64'(bus.port_wr),   64'(1));
      chk("postrst_port_addr", 64'(bus.port_addr), 64'h410);
      repeat (10) @(negedge clk);

`ifdef SDRAM_PORT_QUEUE_TIMEOUT_EN
      // unanswered read: watchdog fires after TO WAIT cycles, then the queued write issues
      auto_rsp = 0;
      push(1'b0, 21'h500, 32'h0, 4'hF);
      push(1'b1, 21'h501, 32'h0000_0501, 4'hF);
      wait_sig("to_rd_issued", 1, 10);
      n = 0;
      while (!bus.rsp_valid && n < 60) begin @(negedge clk); n++; end
      chk("to_latency",  64'(n),               64'(TO + 1));
      chk("to_err",      64'(bus.timeout_err), 64'(1));
      chk("to_rsp_data", 64'(bus.rsp_data),    64'(0));
      auto_rsp = 1;
      wait_sig("to_next_wr", 0, 20);
      chk("to_next_addr", 64'(bus.port_addr), 64'h501);
      repeat (10) @(negedge clk);
      chk("to_err_sticky", 64'(bus.timeout_err), 64'(1));
`else
      // without the watchdog an unanswered read waits indefinitely
      auto_rsp = 0;
      push(1'b0, 21'h500, 32'h0, 4'hF);
      repeat (40) @(negedge clk);
      chk("nto_err",    64'(bus.timeout_err), 64'(0));
      chk("nto_no_rsp", 64'(bus.rsp_valid),   64'(0));
      auto_rsp = 1;
      wait_sig("nto_rsp_seen", 2, 10);
      chk("nto_rsp_data", 64'(bus.rsp_data), 64'(0));
      repeat (5) @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
